// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage - register file, main control decode, immediate generation.
// Optional build macro ID_WB_BYPASS_EN: write-through forwarding of WB_out onto dataA/dataB.
module id_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] WB_out,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic            MemWrite,
    output logic            MemRead,
    output logic            ResultSrc,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic [XLEN-1:0] dataA,
    output logic [XLEN-1:0] dataB,
    output logic [XLEN-1:0] imm_ext,
    output logic [4:0]      rd
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] regs [NREGS];

    // funct3 is consumed by the downstream ALU decoder, not here.
    logic unused_funct3;

    assign opcode        = instruction[6:0];
    assign rs1           = instruction[15 +: AW];
    assign rs2           = instruction[20 +: AW];
    assign rd            = instruction[11:7];
    assign unused_funct3 = ^instruction[14:12];

    always_comb begin
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        ResultSrc = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 2'b00;
        imm_ext   = '0;
        case (opcode)
            OP_R: begin
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_IALU: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = 2'b10;
                imm_ext  = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            end
            OP_LOAD: begin
                RegWrite  = 1'b1;
                ALUSrc    = 1'b1;
                MemRead   = 1'b1;
                ResultSrc = 1'b1;
                imm_ext   = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            end
            OP_STORE: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
                imm_ext  = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            OP_BRANCH: begin
                Branch  = 1'b1;
                ALUOp   = 2'b01;
                imm_ext = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // Reset takes priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (RegWrite && (rd != '0)) begin
            regs[rd] <= WB_out;
        end
    end

    always_comb begin
        dataA = (rs1 == '0) ? '0 : regs[rs1];
        dataB = (rs2 == '0) ? '0 : regs[rs2];
`ifdef ID_WB_BYPASS_EN
        if (RegWrite && !rst && (rd != '0) && (rs1 == rd)) begin
            dataA = WB_out;
        end
        if (RegWrite && !rst && (rd != '0) && (rs2 == rd)) begin
            dataB = WB_out;
        end
`endif
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed, table-driven bench for id_stage decode plus register-file write/reset sequences.
// Expected pre-edge read values depend on ID_WB_BYPASS_EN.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] WB_out;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemWrite;
    logic        MemRead;
    logic        ResultSrc;
    logic        Branch;
    logic [1:0]  ALUOp;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] imm_ext;
    logic [4:0]  rd;

    int checks = 0;
    int errors = 0;

    id_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk),
        .rst(rst),
        .instruction(instruction),
        .WB_out(WB_out),
        .RegWrite(RegWrite),
        .ALUSrc(ALUSrc),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .ResultSrc(ResultSrc),
        .Branch(Branch),
        .ALUOp(ALUOp),
        .dataA(dataA),
        .dataB(dataB),
        .imm_ext(imm_ext),
        .rd(rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, ALUOp[1:0]
    typedef struct {
        logic [31:0] instr;
        logic [7:0]  ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_now();
        return {RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, ALUOp};
    endfunction

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pre;

    initial begin
        vecs[0]  = '{32'h00c58633, 8'b10000010, 32'h00000000, 5'd12}; // add x12,x11,x12
        vecs[1]  = '{32'h00c58593, 8'b11000010, 32'h0000000C, 5'd11}; // addi x11,x11,12
        vecs[2]  = '{32'hfff00093, 8'b11000010, 32'hFFFFFFFF, 5'd1};  // addi x1,x0,-1
        vecs[3]  = '{32'h0045a603, 8'b11011000, 32'h00000004, 5'd12}; // lw x12,4(x11)
        vecs[4]  = '{32'h00c5a223, 8'b01100000, 32'h00000004, 5'd4};  // sw x12,4(x11)
        vecs[5]  = '{32'h00c58663, 8'b00000101, 32'h0000000C, 5'd12}; // beq x11,x12,12
        vecs[6]  = '{32'h00000000, 8'b00000000, 32'h00000000, 5'd0};  // all-zero word
        vecs[7]  = '{32'hfe112e23, 8'b01100000, 32'hFFFFFFFC, 5'd28}; // sw x1,-4(x2)
        vecs[8]  = '{32'hfe000ce3, 8'b00000101, 32'hFFFFFFF8, 5'd25}; // beq x0,x0,-8
        vecs[9]  = '{32'h123450b7, 8'b00000000, 32'h00000000, 5'd1};  // lui: unsupported
        vecs[10] = '{32'hfff02283, 8'b11011000, 32'hFFFFFFFF, 5'd5};  // lw x5,-1(x0)
        vecs[11] = '{32'h402081b3, 8'b10000010, 32'h00000000, 5'd3};  // sub x3,x1,x2

        rst         = 1'b1;
        instruction = 32'h00c58633;
        WB_out      = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dataA", dataA, 32'h0);
        check("reset_dataB", dataB, 32'h0);
        check("reset_ctrl_follows_instr", {24'h0, ctrl_now()}, 32'h00000082);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            instruction = vecs[i].instr;
            #1;
            check($sformatf("vec%0d_ctrl", i), {24'h0, ctrl_now()}, {24'h0, vecs[i].ctrl});
            check($sformatf("vec%0d_imm", i), imm_ext, vecs[i].imm);
            check($sformatf("vec%0d_rd", i), {27'h0, rd}, {27'h0, vecs[i].rd});
            check($sformatf("vec%0d_dataA", i), dataA, 32'h0);
            check($sformatf("vec%0d_dataB", i), dataB, 32'h0);
        end

        // Write x11 via addi; observe old value before the edge (or bypassed value).
        @(negedge clk);
        instruction = 32'h00c58593;
        WB_out      = 32'h1234ABCD;
        #1;
`ifdef ID_WB_BYPASS_EN
        exp_pre = 32'h1234ABCD;
`else
        exp_pre = 32'h0;
`endif
        check("wr_x11_pre_edge_dataA", dataA, exp_pre);
        after_edge();
        check("wr_x11_post_edge_dataA", dataA, 32'h1234ABCD);

        // addi x0: x0 is never written nor bypassed.
        instruction = 32'h00000013;
        #1;
        check("x0_pre_edge_dataA", dataA, 32'h0);
        after_edge();
        check("x0_post_edge_dataA", dataA, 32'h0);

        // add x0,x0,x11: rs2 path reads x11, x0 write discarded.
        instruction = 32'h00B00033;
        WB_out      = 32'h99999999;
        #1;
        check("rs2_read_x11_pre", dataB, 32'h1234ABCD);
        after_edge();
        check("rs2_read_x11_post", dataB, 32'h1234ABCD);
        check("x0_after_rd0_write", dataA, 32'h0);

        // Store must not write its rd field (x4).
        instruction = 32'h00c5a223;
        WB_out      = 32'h55555555;
        #1;
        check("store_rs1_x11", dataA, 32'h1234ABCD);
        after_edge();
        instruction = 32'h00020013;
        #1;
        check("store_no_write_x4", dataA, 32'h0);

        // Write x12 via add, rs2==rd exercises the rs2 bypass path.
        instruction = 32'h00c58633;
        WB_out      = 32'hCAFEF00D;
        #1;
`ifdef ID_WB_BYPASS_EN
        exp_pre = 32'hCAFEF00D;
`else
        exp_pre = 32'h0;
`endif
        check("wr_x12_pre_edge_dataA", dataA, 32'h1234ABCD);
        check("wr_x12_pre_edge_dataB", dataB, exp_pre);
        after_edge();
        instruction = 32'h00c58663;
        WB_out      = 32'h0;
        #1;
        check("beq_reads_x11", dataA, 32'h1234ABCD);
        check("beq_reads_x12", dataB, 32'hCAFEF00D);

        // Reset with a pending write: reset wins, no bypass during reset.
        instruction = 32'h00c58593;
        WB_out      = 32'h77777777;
        rst         = 1'b1;
        #1;
        check("rst_regwrite_follows_instr", {31'h0, RegWrite}, 32'h1);
        check("rst_no_bypass_dataA", dataA, 32'h1234ABCD);
        after_edge();
        rst         = 1'b0;
        instruction = 32'h00c58663;
        WB_out      = 32'h0;
        #1;
        check("post_rst_x11", dataA, 32'h0);
        check("post_rst_x12", dataB, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the single-cycle RV32I core; sits between instruction fetch and execute.
- Holds the 32x32 architectural register file and generates main control signals, the sign-extended immediate and the destination register index.
- Writeback data from the end of the datapath returns on WB_out and is written into the register file.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, number of architectural registers; index width log2(NREGS)=5

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- instruction  in  32  current instruction word
- WB_out  in  32  writeback data, written to rd
- RegWrite  out  1  register write enable (also gates internal write)
- ALUSrc  out  1  0=dataB, 1=imm_ext as ALU operand B
- MemWrite  out  1  data-memory store enable
- MemRead  out  1  data-memory load enable
- ResultSrc  out  1  0=ALU result, 1=memory data to writeback
- Branch  out  1  conditional branch instruction
- ALUOp  out  2  00=add (address), 01=subtract/compare, 10=decode funct3/funct7
- dataA  out  32  register file read of rs1=instruction[19:15]
- dataB  out  32  register file read of rs2=instruction[24:20]
- imm_ext  out  32  sign-extended immediate
- rd  out  5  instruction[11:7]

Behaviour:
- All outputs except the register-file contents are purely combinational from instruction; zero latency.
- Control decode by opcode instruction[6:0]. Field order: RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, ALUOp.
  - 0110011 R-type: 1,0,0,0,0,0,10
  - 0010011 I-ALU: 1,1,0,0,0,0,10
  - 0000011 load: 1,1,0,1,1,0,00
  - 0100011 store: 0,1,1,0,0,0,00
  - 1100011 branch: 0,0,0,0,0,1,01
  - any other opcode, including 0x00000000: all zero
- Immediate, all sign-extended from instruction[31]:
  - I-type (0010011, 0000011): instruction[31:20]
  - S-type: {instruction[31:25], instruction[11:7]}
  - B-type: {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}
  - R-type and unknown opcodes: 0
- Register file reads: asynchronous and combinational; index 0 always reads 0.
- Register file write: on rising clk when RegWrite=1 and rst=0, write WB_out to register rd.
  - rd=0 writes are discarded.
  - Write-then-read: new value appears on dataA/dataB after the edge.
- Without the optional feature, same-cycle read of the register being written returns the old value.
- Reset: on rising clk with rst=1, all 32 registers are cleared to 0 and no write occurs.
  - Control/imm/rd outputs still follow instruction during reset.
  - Reset asserted mid-operation overrides any pending write on that edge.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- When defined: write-through forwarding. If RegWrite=1, rst=0, rd!=0 and rs1==rd (resp. rs2==rd), dataA (resp. dataB) returns WB_out combinationally in the same cycle.
- When undefined: the old register value is returned until the clock edge.
- x0 is never bypassed.

Test Plan:
- Reset for 2 cycles, then instruction=0x00c58633 (add x12,x11,x12) -> RegWrite=1 ALUSrc=0 MemWrite=0 MemRead=0 ResultSrc=0 Branch=0 ALUOp=10, imm_ext=0, rd=12, dataA=dataB=0.
- 0x00c58593 (addi x11,x11,12) -> RegWrite=1 ALUSrc=1 ALUOp=10, imm_ext=0x0000000C, rd=11; 0xfff00093 -> imm_ext=0xFFFFFFFF, rd=1.
- 0x0045a603 (lw x12,4(x11)) -> RegWrite=1 ALUSrc=1 MemRead=1 ResultSrc=1 ALUOp=00, imm_ext=4, rd=12; 0x00c5a223 (sw) -> RegWrite=0 ALUSrc=1 MemWrite=1 ALUOp=00, imm_ext=4.
- 0x00c58663 (beq x11,x12,12) -> Branch=1 ALUOp=01 RegWrite=0 ALUSrc=0, imm_ext=0x0000000C.
- Write path:
  - addi x11 with WB_out=0x1234ABCD, one clock edge -> dataA=0x1234ABCD (rs1=x11).
  - Same WB_out with rd=0 (0x00000013) -> x0 still reads 0.
  - rst=1 one edge -> x11 reads 0.
- ID_WB_BYPASS_EN defined: addi x11 with WB_out=0xDEADBEEF -> dataA=0xDEADBEEF before the edge; undefined -> previous value until edge.
